// File: rtl/gray_burst_ctrl_if.sv
// Control and status bundle for gray_burst_ctrl.
// The master drives burst requests; the slave returns the Gray count and status.
interface gray_burst_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] len;
  logic             repeat_en;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] gr;
  logic             busy;
  logic             done;

  modport master (
    output start, len, repeat_en, pause, abort,
    input  gr, busy, done
  );

  modport slave (
    input  start, len, repeat_en, pause, abort,
    output gr, busy, done
  );
endinterface

// File: rtl/gray_burst_ctrl.sv
// Burst sequencer for a binary up-counter.
// The count is presented as registered Gray code.
module gray_burst_ctrl #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  gray_burst_ctrl_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] gr_q;
  logic [WIDTH:0]   rem, rem_n;
  logic [WIDTH:0]   len_q, len_q_n;
  logic [WIDTH:0]   len_ext;

  // A zero length requests a full wrap of the counter.
  assign len_ext = (bus.len == '0)
                 ? {1'b1, {WIDTH{1'b0}}}
                 : {1'b0, bus.len};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    len_q_n = len_q;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          len_q_n = len_ext;
          rem_n   = len_ext;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (bus.pause) begin
          state_n = HOLD;
        end else begin
          cnt_n = cnt + 1'b1;
          rem_n = rem - 1'b1;
          if (rem == {{WIDTH{1'b0}}, 1'b1})
            state_n = DONE;
        end
      end
      HOLD: begin
        if (bus.abort)
          state_n = IDLE;
        else if (!bus.pause)
          state_n = RUN;
      end
      DONE: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (bus.repeat_en) begin
          rem_n   = len_q;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gray register tracks the next count so it matches cnt with no lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      len_q <= '0;
      gr_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      len_q <= len_q_n;
      gr_q  <= cnt_n ^ (cnt_n >> 1);
    end
  end

  assign bus.gr   = gr_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_gray_burst_ctrl.sv
// Directed and random bursts for gray_burst_ctrl.
// Outputs are compared against a cycle model built from the burst rules.
module tb_gray_burst_ctrl;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk;
  logic rst;

  gray_burst_ctrl_if #(.WIDTH(W)) bus ();

  gray_burst_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: burst activity flags plus integer count/remaining/length.
  bit m_busy;
  bit m_hold;
  bit m_fin;
  int m_cnt;
  int m_rem;
  int m_len;

  int dut_dones;
  int mdl_dones;

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_hold = 0;
    m_fin  = 0;
    m_cnt  = 0;
    m_rem  = 0;
    m_len  = 0;
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (bus.start && !bus.abort) begin
        m_len  = (bus.len == 0) ? MOD : int'(bus.len);
        m_rem  = m_len;
        m_cnt  = 0;
        m_busy = 1;
        m_hold = 0;
        m_fin  = 0;
      end
    end else if (m_fin) begin
      m_fin = 0;
      if (bus.abort)          m_busy = 0;
      else if (bus.repeat_en) m_rem  = m_len;
      else                    m_busy = 0;
    end else if (bus.abort) begin
      m_busy = 0;
      m_hold = 0;
    end else if (m_hold) begin
      if (!bus.pause) m_hold = 0;
    end else if (bus.pause) begin
      m_hold = 1;
    end else begin
      m_cnt = (m_cnt + 1) % MOD;
      m_rem = m_rem - 1;
      if (m_rem == 0) m_fin = 1;
    end
  endtask

  task automatic step();
    bit prev_busy;
    int prev_gr;
    prev_busy = m_busy;
    prev_gr   = gray(m_cnt);
    @(posedge clk);
    model_edge();
    #1;
    chk("gr",   int'(bus.gr),   gray(m_cnt));
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("done", int'(bus.done), int'(m_fin));
    if (bus.done) dut_dones++;
    if (m_fin)    mdl_dones++;
    if (prev_busy && m_busy)
      chk("onebit", int'($countones(bus.gr ^ prev_gr[W-1:0]) <= 1), 1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input bit st, input int ln, input bit rp,
                       input bit pa, input bit ab);
    bus.start     = st;
    bus.len       = ln[W-1:0];
    bus.repeat_en = rp;
    bus.pause     = pa;
    bus.abort     = ab;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    rst = 1'b1;
    #1;
    chk("rst_gr",   int'(bus.gr),   0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    #12;
    rst = 1'b0;

    // len=3 single burst
    drive(1, 3, 0, 0, 0);
    step();
    drive(0, 9, 0, 0, 0);
    steps(3);
    chk("len3_gr_end", int'(bus.gr), 4'b0010);
    chk("len3_done", int'(bus.done), 1);
    steps(2);
    chk("len3_idle_gr", int'(bus.gr), 4'b0010);

    // len=0 is a full 16-count burst with one done
    dut_dones = 0;
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    steps(16);
    chk("len0_wrap_gr", int'(bus.gr), 0);
    steps(3);
    chk("len0_done_once", dut_dones, 1);

    // len=5 with a 3-cycle pause after the 2nd increment
    dut_dones = 0;
    drive(1, 5, 0, 0, 0);
    step();
    drive(0, 5, 0, 0, 0);
    steps(2);
    drive(0, 5, 0, 1, 0);
    steps(3);
    chk("pause_hold_gr", int'(bus.gr), 4'b0011);
    drive(0, 5, 0, 0, 0);
    steps(6);
    chk("pause_end_gr", int'(bus.gr), 4'b0111);
    steps(2);
    chk("pause_done_once", dut_dones, 1);

    // len=4: start mid-burst ignored, then abort after 2nd increment
    dut_dones = 0;
    drive(1, 4, 0, 0, 0);
    step();
    drive(0, 4, 0, 0, 0);
    step();
    drive(1, 15, 0, 0, 0);
    step();
    drive(0, 1, 0, 0, 1);
    step();
    drive(0, 1, 0, 0, 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_gr",   int'(bus.gr),   4'b0011);
    steps(4);
    chk("abort_no_done", dut_dones, 0);

    // auto-repeat len=6 across a counter wrap
    dut_dones = 0;
    mdl_dones = 0;
    drive(1, 6, 1, 0, 0);
    step();
    drive(0, 2, 1, 0, 0);
    steps(40);
    chk("repeat_dones", dut_dones, mdl_dones);
    drive(0, 2, 0, 0, 0);
    steps(10);

    // asynchronous reset mid-run
    drive(1, 9, 0, 0, 0);
    step();
    drive(0, 9, 0, 0, 0);
    steps(3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_gr",   int'(bus.gr),   0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    #1;
    rst = 1'b0;
    dut_dones = 0;
    drive(1, 2, 0, 0, 0);
    step();
    drive(0, 2, 0, 0, 0);
    steps(2);
    chk("post_rst_gr", int'(bus.gr), 4'b0011);
    steps(2);
    chk("post_rst_done", dut_dones, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) == 0,
            int'($urandom_range(0, MOD - 1)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 19) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
